multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer FSM for the 60-bit processor. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives PC, IR, ALU, register-file and memory control strobes from the 4-bit opcode.
- It handles req/ack handshakes to instruction memory and data memory, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- MEM_TIMEOUT, 16, watchdog limit in cycles; used only with SEQ_WATCHDOG_EN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- instr_opcode  in  4  opcode field (IR[59:56]); valid from DECODE onward
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- imem_ack  in  1  instruction memory accepted/returned word
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load IR
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= branch/jump target
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write (valid with dmem_req)
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or
- immediate_en  out  1  ALU B operand from immediate
- branch_en  out  1  branch instruction in EXEC
- jump_en  out  1  jump instruction in EXEC
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback source is memory
- illegal_op  out  1  one-cycle pulse on undefined opcode
- halted  out  1  sequencer in HALT
- fault  out  1  watchdog fault (0 without feature)
- retired_cnt  out  CNT_W  instructions retired, wraps

Behaviour:
- Clocking and reset: one clock clk. rst is synchronous, active-high. On the next edge: state = IDLE, opcode_q = 0, retired_cnt = 0, watchdog counter = 0.
- Output derivation: all outputs are decoded from state, opcode_q and the ack/zero inputs. With rst held, every output is 0.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 BEQ, 9 JMP, F HALT. A–E are illegal.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH:
  - imem_req=1 and held until imem_ack. An ack in the first FETCH cycle is accepted.
  - On the ack cycle: ir_load=1, pc_inc=1, -> DECODE.
- DECODE:
  - opcode_q <= instr_opcode.
  - Next state: F -> HALT; illegal -> illegal_op=1 and FETCH; otherwise -> EXEC.
- EXEC:
  - alu_op: SUB and BEQ = 01; AND = 10; OR = 11; all others = 00.
  - immediate_en = ADDI|LD|ST. branch_en = BEQ. jump_en = JMP.
  - pc_load = JMP | (BEQ & alu_zero).
  - Next state: LD/ST -> MEM; ADD/SUB/AND/OR/ADDI -> WB; NOP/BEQ/JMP -> FETCH.
- MEM:
  - dmem_req=1, dmem_we = ST, held until dmem_ack.
  - On ack: LD -> WB, ST -> FETCH.
- WB: reg_write=1, mem_to_reg = LD, -> FETCH.
- HALT: halted=1, no requests issued. Stays until rst; start is ignored.
- Acks: an ack while the matching req=0 is ignored. A request never drops before its ack unless rst (or fault) occurs.
- Retirement: retired_cnt increments by 1 on each edge leaving EXEC/MEM/WB toward FETCH, on DECODE->FETCH (illegal), and on DECODE->HALT. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - NOP/BEQ/JMP: 3 cycles
  - ALU ops: 4 cycles
  - ST: 4 cycles
  - LD: 5 cycles
- Reset mid-operation: outstanding requests are dropped at the next edge. Late acks arriving in IDLE are ignored.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs while in FETCH or MEM with the matching ack low, and clears on entering either state.
  - When it reaches MEM_TIMEOUT-1 with no ack, the FSM goes to FAULT: fault=1, all other outputs 0, exit only by rst.
  - An ack in the same cycle as expiry wins; no fault is raised.
- Undefined: no counter, no FAULT state, fault tied 0, memory waits are unbounded.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP … OP_HALT)
  - alu_op encodings
  - the state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT)
- The core FSM stays a single module.
- With the feature enabled, the timeout counter is the sub-module seq_watchdog (ports: clk, rst, arm, ack, expired; parameter MEM_TIMEOUT).

Test Plan:
- ADD with imem_ack tied 1: rst, then pulse start -> imem_req in cycle 1; reg_write=1 at cycle 4; retired_cnt=1 after cycle 4; alu_op=00 in EXEC.
- LD with dmem_ack arriving 3 cycles after dmem_req rises -> dmem_req held exactly 3 cycles with dmem_we=0; WB has reg_write=1 and mem_to_reg=1; total 7 cycles.
- BEQ: alu_zero=1 -> pc_load=1 and branch_en=1 in EXEC. Repeat with alu_zero=0 -> pc_load=0. Both return to FETCH after 3 cycles.
- Opcode 4'hB -> illegal_op pulses 1 cycle in DECODE; next state FETCH; retired_cnt +1.
- Opcode F -> halted=1 from cycle 3 onward. A later start=1 is ignored. rst -> halted=0, retired_cnt=0.
- SEQ_WATCHDOG_EN with MEM_TIMEOUT=16 and imem_ack held 0 -> fault=1 after 16 FETCH cycles with imem_req=0. Separately: rst asserted mid-MEM -> dmem_req=0 on the next cycle, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 60-bit processor sequencer: opcodes, ALU
// operation encodings, the sequencer state type and an opcode legality helper.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    // Opcodes A..E are undefined; everything up to JMP plus HALT is legal.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait watchdog for the sequencer; only built when SEQ_WATCHDOG_EN is
// defined. Counts armed cycles without an ack and flags the final cycle.
`ifdef SEQ_WATCHDOG_EN
module seq_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic ack,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle outside a wait state (or an ack) restarts the count, so each
    // entry into FETCH or MEM begins from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!arm || ack) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = arm && !ack && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction count.
// Optional memory-wait watchdog (FAULT state) is enabled by SEQ_WATCHDOG_EN.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       instr_opcode,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [1:0]       alu_op,
    output logic             immediate_en,
    output logic             branch_en,
    output logic             jump_en,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       dbg_state
);

    state_t           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q;
    logic             wd_expired;
    logic             retire;

`ifdef SEQ_WATCHDOG_EN
    logic wd_arm;
    logic wd_ack;

    assign wd_arm = (state_q == FETCH) || (state_q == MEM);
    assign wd_ack = (state_q == FETCH) ? imem_ack : dmem_ack;

    seq_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .arm    (wd_arm),
        .ack    (wd_ack),
        .expired(wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (MEM_TIMEOUT != 0);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next state. Requests in FETCH/MEM hold until their ack; an ack in the
    // expiry cycle takes priority over the watchdog.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack)        state_d = DECODE;
                else if (wd_expired) state_d = FAULT;
            end
            DECODE: begin
                opcode_d = instr_opcode;
                if (instr_opcode == OP_HALT)     state_d = HALT;
                else if (!op_is_legal(instr_opcode)) state_d = FETCH;
                else                             state_d = EXEC;
            end
            EXEC: begin
                if (opcode_q == OP_LD || opcode_q == OP_ST) begin
                    state_d = MEM;
                end else if (opcode_q == OP_NOP || opcode_q == OP_BEQ ||
                             opcode_q == OP_JMP) begin
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_ack)        state_d = (opcode_q == OP_LD) ? WB : FETCH;
                else if (wd_expired) state_d = FAULT;
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // An instruction retires when it completes toward FETCH, including an
    // illegal opcode dropped in DECODE and the HALT instruction itself.
    assign retire = ((state_q == EXEC) || (state_q == MEM) || (state_q == WB) ||
                     (state_q == DECODE)) &&
                    ((state_d == FETCH) || (state_d == HALT));

    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_op       = ALU_ADD;
        immediate_en = 1'b0;
        branch_en    = 1'b0;
        jump_en      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        illegal_op   = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        if (!rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                    pc_inc   = imem_ack;
                end
                DECODE: begin
                    illegal_op = !op_is_legal(instr_opcode);
                end
                EXEC: begin
                    if (opcode_q == OP_SUB || opcode_q == OP_BEQ) alu_op = ALU_SUB;
                    else if (opcode_q == OP_AND)                  alu_op = ALU_AND;
                    else if (opcode_q == OP_OR)                   alu_op = ALU_OR;
                    immediate_en = (opcode_q == OP_ADDI) || (opcode_q == OP_LD) ||
                                   (opcode_q == OP_ST);
                    branch_en    = (opcode_q == OP_BEQ);
                    jump_en      = (opcode_q == OP_JMP);
                    pc_load      = (opcode_q == OP_JMP) ||
                                   ((opcode_q == OP_BEQ) && alu_zero);
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode_q == OP_ST);
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode_q == OP_LD);
                end
                HALT:    halted = 1'b1;
                FAULT:   fault  = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired_cnt = rst ? '0 : cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer: per-cycle expected control
// vectors for each instruction class, reset, halt and memory-wait behaviour.
module tb_multicycle_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  instr_opcode;
    logic        alu_zero;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we;
    logic [1:0]  alu_op;
    logic        immediate_en, branch_en, jump_en, reg_write, mem_to_reg;
    logic        illegal_op, halted, fault;
    logic [31:0] retired_cnt;
    logic [2:0]  dbg_state;
    logic [15:0] outs;

    int checks = 0;
    int errors = 0;

    // {imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, alu_op[1:0],
    //  immediate_en, branch_en, jump_en, reg_write, mem_to_reg, illegal_op, halted, fault}
    assign outs = {imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, alu_op,
                   immediate_en, branch_en, jump_en, reg_write, mem_to_reg,
                   illegal_op, halted, fault};

    multicycle_sequencer #(
        .CNT_W      (32),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr_opcode(instr_opcode),
        .alu_zero    (alu_zero),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .alu_op      (alu_op),
        .immediate_en(immediate_en),
        .branch_en   (branch_en),
        .jump_en     (jump_en),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .illegal_op  (illegal_op),
        .halted      (halted),
        .fault       (fault),
        .retired_cnt (retired_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; instr_opcode = OP_NOP; alu_zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (outs !== 16'h0000) begin
            errors++; $display("FAIL reset_outs got %h want %h", outs, 16'h0000);
        end
        checks++;
        if (dbg_state !== IDLE || retired_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_state got st=%0d cnt=%0d want st=0 cnt=0", dbg_state, retired_cnt);
        end
        // acks while idle with no start must not move the FSM
        imem_ack = 1'b1; dmem_ack = 1'b1;
        tick();
        #1;
        checks++;
        if (dbg_state !== IDLE || outs !== 16'h0000) begin
            errors++; $display("FAIL idle_ack_ignored got st=%0d outs=%h want st=0 outs=0000", dbg_state, outs);
        end
    endtask

    task automatic test_add();
        logic [15:0] exp [1:5] = '{16'hE000, 16'h0000, 16'h0000, 16'h0010, 16'hE000};
        do_reset();
        imem_ack = 1'b1; instr_opcode = OP_ADD; start = 1'b1;
        #1;
        checks++;
        if (outs !== 16'h0000) begin
            errors++; $display("FAIL add_cyc0 got %h want %h", outs, 16'h0000);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            #1;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL add_cyc%0d got %h want %h", c, outs, exp[c]);
            end
            if (c == 4) begin
                checks++;
                if (retired_cnt !== 32'd0) begin
                    errors++; $display("FAIL add_cnt_wb got %0d want 0", retired_cnt);
                end
            end
        end
        checks++;
        if (retired_cnt !== 32'd1) begin
            errors++; $display("FAIL add_cnt got %0d want 1", retired_cnt);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [1:20] = '{OP_SUB, OP_SUB, OP_SUB, OP_SUB, OP_AND, OP_AND, OP_AND, OP_AND,
                                    OP_OR, OP_OR, OP_OR, OP_OR, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                                    OP_NOP, OP_NOP, OP_NOP, OP_NOP};
        logic [15:0] exp [1:20] = '{16'hE000, 16'h0000, 16'h0100, 16'h0010,
                                    16'hE000, 16'h0000, 16'h0200, 16'h0010,
                                    16'hE000, 16'h0000, 16'h0300, 16'h0010,
                                    16'hE000, 16'h0000, 16'h0080, 16'h0010,
                                    16'hE000, 16'h0000, 16'h0000, 16'h8000};
        do_reset();
        imem_ack = 1'b1; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
            instr_opcode = ops[c];
            imem_ack = (c < 20);
            #1;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL alu_cyc%0d got %h want %h", c, outs, exp[c]);
            end
        end
        checks++;
        if (retired_cnt !== 32'd5) begin
            errors++; $display("FAIL alu_cnt got %0d want 5", retired_cnt);
        end
    endtask

    task automatic test_load();
        logic [15:0] exp [1:8] = '{16'hE000, 16'h0000, 16'h0080, 16'h0800,
                                   16'h0800, 16'h0800, 16'h0018, 16'h8000};
        int req_cycles = 0;
        do_reset();
        instr_opcode = OP_LD; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
            imem_ack = (c == 1);
            dmem_ack = (c == 6);
            #1;
            if (dmem_req) req_cycles++;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL ld_cyc%0d got %h want %h", c, outs, exp[c]);
            end
        end
        checks++;
        if (req_cycles != 3) begin
            errors++; $display("FAIL ld_req_len got %0d want 3", req_cycles);
        end
        checks++;
        if (retired_cnt !== 32'd1) begin
            errors++; $display("FAIL ld_cnt got %0d want 1", retired_cnt);
        end
    endtask

    task automatic test_store();
        logic [15:0] exp [1:5] = '{16'hE000, 16'h0000, 16'h0080, 16'h0C00, 16'h8000};
        do_reset();
        instr_opcode = OP_ST; start = 1'b1;
        dmem_ack = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            imem_ack = (c == 1);
            #1;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL st_cyc%0d got %h want %h", c, outs, exp[c]);
            end
        end
        checks++;
        if (retired_cnt !== 32'd1) begin
            errors++; $display("FAIL st_cnt got %0d want 1", retired_cnt);
        end
    endtask

    task automatic test_branch();
        logic [3:0]  ops  [1:10] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ,
                                     OP_JMP, OP_JMP, OP_JMP, OP_JMP};
        logic        zero [1:10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] exp  [1:10] = '{16'hE000, 16'h0000, 16'h1140, 16'hE000, 16'h0000,
                                     16'h0140, 16'hE000, 16'h0000, 16'h1020, 16'h8000};
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            instr_opcode = ops[c];
            alu_zero = zero[c];
            imem_ack = (c < 10);
            #1;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL br_cyc%0d got %h want %h", c, outs, exp[c]);
            end
        end
        checks++;
        if (retired_cnt !== 32'd3) begin
            errors++; $display("FAIL br_cnt got %0d want 3", retired_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp [1:4] = '{16'hE000, 16'h0004, 16'h8000, 16'h8000};
        do_reset();
        instr_opcode = 4'hB; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            imem_ack = (c == 1);
            #1;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL ill_cyc%0d got %h want %h", c, outs, exp[c]);
            end
        end
        checks++;
        if (retired_cnt !== 32'd1) begin
            errors++; $display("FAIL ill_cnt got %0d want 1", retired_cnt);
        end
    endtask

    task automatic test_halt();
        logic [15:0] exp [1:6] = '{16'hE000, 16'h0000, 16'h0002, 16'h0002, 16'h0002, 16'h0002};
        do_reset();
        instr_opcode = OP_HALT; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            imem_ack = 1'b1;
            start = (c >= 3);
            #1;
            checks++;
            if (outs !== exp[c]) begin
                errors++; $display("FAIL halt_cyc%0d got %h want %h", c, outs, exp[c]);
            end
        end
        checks++;
        if (retired_cnt !== 32'd1 || dbg_state !== HALT) begin
            errors++; $display("FAIL halt_state got cnt=%0d st=%0d want cnt=1 st=%0d", retired_cnt, dbg_state, HALT);
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 16'h0000 || retired_cnt !== 32'd0) begin
            errors++; $display("FAIL halt_rst_held got outs=%h cnt=%0d want 0000 0", outs, retired_cnt);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || retired_cnt !== 32'd0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL halt_rst got h=%b cnt=%0d st=%0d want 0 0 0", halted, retired_cnt, dbg_state);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        instr_opcode = OP_LD; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            imem_ack = (c == 1);
        end
        #1;
        checks++;
        if (outs !== 16'h0800) begin
            errors++; $display("FAIL mid_mem_req got %h want %h", outs, 16'h0800);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL mid_mem_drop got req=%b st=%0d want 0 0", dmem_req, dbg_state);
        end
        dmem_ack = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== 16'h0000 || dbg_state !== IDLE) begin
            errors++; $display("FAIL late_ack got outs=%h st=%0d want 0000 0", outs, dbg_state);
        end
    endtask

`ifdef SEQ_WATCHDOG_EN
    task automatic test_fetch_wait();
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            start = 1'b0;
            #1;
            checks++;
            if (outs !== ((c <= 16) ? 16'h8000 : 16'h0001)) begin
                errors++; $display("FAIL wd_cyc%0d got %h want %h", c, outs, (c <= 16) ? 16'h8000 : 16'h0001);
            end
        end
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            start = 1'b0;
            imem_ack = (c == 16);
            #1;
        end
        checks++;
        if (dbg_state !== DECODE || fault !== 1'b0) begin
            errors++; $display("FAIL wd_ack_wins got st=%0d fault=%b want st=%0d fault=0", dbg_state, fault, DECODE);
        end
    endtask
`else
    task automatic test_fetch_wait();
        int bad = 0;
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            #1;
            if (outs !== 16'h8000) bad++;
        end
        checks++;
        if (bad != 0 || dbg_state !== FETCH) begin
            errors++; $display("FAIL fetch_wait got %0d bad cycles st=%0d want 0 st=%0d", bad, dbg_state, FETCH);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_halt();
        test_reset_mid_mem();
        test_fetch_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
